// File: rtl/regfile_if.sv
// Bus bundle for the register file: one write port and two combinational read ports.
interface regfile_if #(
  parameter int unsigned N = 3,
  parameter int unsigned W = 8
) ();
  logic         we;
  logic [N-1:0] addr_rd;
  logic [N-1:0] addr_rs1;
  logic [N-1:0] addr_rs2;
  logic [W-1:0] data_in;
  logic [W-1:0] rs1;
  logic [W-1:0] rs2;

  modport master (
    output we, addr_rd, addr_rs1, addr_rs2, data_in,
    input  rs1, rs2
  );

  modport slave (
    input  we, addr_rd, addr_rs1, addr_rs2, data_in,
    output rs1, rs2
  );
endinterface

// File: rtl/regfile.sv
// 2**N x W register file, register 0 hardwired to zero, async active-high reset,
// one synchronous write port and two zero-latency read ports without write bypass.
module regfile #(
  parameter int unsigned N = 3,
  parameter int unsigned W = 8
) (
  input logic       clk,
  input logic       rst,
  regfile_if.slave  bus
);

  localparam int unsigned Depth = 2 ** N;

  logic [W-1:0] regs_q [Depth];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        regs_q[i] <= '0;
      end
    end else if (bus.we && (bus.addr_rd != '0)) begin
      regs_q[bus.addr_rd] <= bus.data_in;
    end
  end

  // Gating with rst keeps the outputs at zero for the whole reset window.
  always_comb begin
    bus.rs1 = '0;
    bus.rs2 = '0;
    if (!rst && (bus.addr_rs1 != '0)) begin
      bus.rs1 = regs_q[bus.addr_rs1];
    end
    if (!rst && (bus.addr_rs2 != '0)) begin
      bus.rs2 = regs_q[bus.addr_rs2];
    end
  end

endmodule

// File: tb/tb_regfile.sv
// Randomised and directed bench for regfile: driver pushes expected read data into a
// scoreboard queue, a monitor on the falling edge pops and compares against the DUT.
module tb_regfile;

  localparam int unsigned N = 3;
  localparam int unsigned W = 8;
  localparam int unsigned Regs = 2 ** N;

  typedef struct {
    logic [W-1:0] e1;
    logic [W-1:0] e2;
    string        tag;
  } exp_t;

  logic clk;
  logic rst;

  regfile_if #(.N(N), .W(W)) bus ();

  regfile #(.N(N), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: plain array of register contents plus the write committed by the
  // next rising edge.
  logic [W-1:0] mdl [Regs];
  logic         pend_we;
  int           pend_rd;
  logic [W-1:0] pend_d;

  exp_t exp_q[$];
  int   n_checks;
  int   n_fail;

  task automatic drive(input logic r, input logic w, input int rd, input int a1,
                       input int a2, input logic [W-1:0] d, input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (pend_we) mdl[pend_rd] = pend_d;
    pend_we = 1'b0;
    rst = r;
    bus.we = w;
    bus.addr_rd = N'(rd);
    bus.addr_rs1 = N'(a1);
    bus.addr_rs2 = N'(a2);
    bus.data_in = d;
    if (r) begin
      for (int i = 0; i < int'(Regs); i++) mdl[i] = '0;
    end
    e.e1 = r ? '0 : mdl[a1];
    e.e2 = r ? '0 : mdl[a2];
    e.tag = tag;
    exp_q.push_back(e);
    if (w && !r && rd != 0) begin
      pend_we = 1'b1;
      pend_rd = rd;
      pend_d  = d;
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_checks++;
      if (bus.rs1 !== e.e1) begin
        n_fail++;
        $display("FAIL %s rs1: got %h expected %h (addr %0d) at %0t",
                 e.tag, bus.rs1, e.e1, bus.addr_rs1, $time);
      end
      n_checks++;
      if (bus.rs2 !== e.e2) begin
        n_fail++;
        $display("FAIL %s rs2: got %h expected %h (addr %0d) at %0t",
                 e.tag, bus.rs2, e.e2, bus.addr_rs2, $time);
      end
    end
  end

  initial begin
    n_checks = 0;
    n_fail = 0;
    pend_we = 1'b0;
    pend_rd = 0;
    pend_d = '0;
    for (int i = 0; i < int'(Regs); i++) mdl[i] = '0;
    rst = 1'b1;
    bus.we = 1'b0;
    bus.addr_rd = '0;
    bus.addr_rs1 = '0;
    bus.addr_rs2 = '0;
    bus.data_in = '0;

    // Held in reset: reads are zero and writes are dropped.
    for (int i = 0; i < int'(Regs); i++) drive(1'b1, 1'b1, i, i, int'(Regs) - 1 - i, 8'hFF, "rst_hold");
    for (int i = 0; i < int'(Regs); i++) drive(1'b0, 1'b0, 0, i, (i + 1) % int'(Regs), '0, "post_rst");

    for (int i = 1; i < int'(Regs); i++) drive(1'b0, 1'b1, i, 0, i, W'(8'h11 * i), "fill");
    for (int i = 0; i < int'(Regs); i++) drive(1'b0, 1'b0, 0, i, i, '0, "fill_rd");

    drive(1'b0, 1'b1, 0, 0, 0, 8'hFF, "wr0");
    drive(1'b0, 1'b0, 0, 0, 0, '0, "wr0_rd");

    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 3, 3, 3, 8'hAA, "we_low");
    drive(1'b0, 1'b0, 0, 3, 2, '0, "we_low_rd");

    drive(1'b0, 1'b1, 5, 5, 5, 8'h5A, "raw_pre");
    drive(1'b0, 1'b0, 0, 5, 5, '0, "raw_post");

    for (int k = 0; k < 300; k++) begin
      drive(($urandom_range(0, 39) == 0), 1'($urandom), int'($urandom_range(0, Regs - 1)),
            int'($urandom_range(0, Regs - 1)), int'($urandom_range(0, Regs - 1)),
            W'($urandom), "rand");
    end

    // Refill, then raise rst mid-cycle; the falling-edge sample precedes the next rise.
    drive(1'b0, 1'b0, 0, 0, 0, '0, "refill_rel");
    for (int i = 1; i < int'(Regs); i++) drive(1'b0, 1'b1, i, i, 0, W'(8'h11 * i), "refill");
    for (int i = 0; i < int'(Regs); i++) drive(1'b1, 1'b0, 0, i, int'(Regs) - 1 - i, '0, "async_rst");
    drive(1'b0, 1'b1, 6, 6, 0, 8'hC3, "first_wr");
    drive(1'b0, 1'b0, 0, 6, 7, '0, "first_wr_rd");

    for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
